// File: rtl/sram_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// sram_req_arbiter_pkg : shared types and default sizing for the SRAM arbiter
// Revision: 1.0
// ============================================================================
package sram_req_arbiter_pkg;

  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } req_id_t;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  localparam int unsigned C_MAX_OUTSTANDING = 4;
  localparam int unsigned C_STARVE_LIMIT    = 4;

endpackage
`default_nettype wire

// File: rtl/sram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// sram_req_arbiter_if : one SRAM-like request/response port
// Revision: 1.0
// ============================================================================
interface sram_req_arbiter_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // master issues requests, slave accepts them and returns data
  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface
`default_nettype wire

// File: rtl/sram_req_arbiter_req_order_fifo.sv
`default_nettype none
// ============================================================================
// req_order_fifo : 1-bit synchronous FIFO recording requester issue order
// Revision: 1.0
// ============================================================================
module req_order_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       push,
  input  wire logic                       din,
  input  wire logic                       pop,
  output logic                            dout,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // a push at full is legal only when a pop frees the slot in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// sram_req_arbiter : shares one SRAM bus between inst-fetch and data ports
// Revision: 1.0
// ============================================================================
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = C_MAX_OUTSTANDING,
  parameter int unsigned STARVE_LIMIT    = C_STARVE_LIMIT
) (
  input  wire logic                           clk,
  input  wire logic                           reset,
  sram_req_arbiter_if.slave                   inst,
  sram_req_arbiter_if.slave                   data,
  sram_req_arbiter_if.master                  bus,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
  output logic                                err_stray_ok
);

  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);

  sram_req_t            inst_pkt, data_pkt, grant_pkt;
  req_id_t              grant_id;
  req_id_t              lock_id_q, lock_id_d;
  logic                 lock_q, lock_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  logic                 err_q, err_d;
  logic                 fifo_full, fifo_empty, fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 push, pop, starved;

  always_comb begin
    inst_pkt = '{req: inst.req, wr: inst.wr, size: inst.size,
                 wstrb: inst.wstrb, addr: inst.addr, wdata: inst.wdata};
    data_pkt = '{req: data.req, wr: data.wr, size: data.size,
                 wstrb: data.wstrb, addr: data.addr, wdata: data.wdata};
  end

  assign starved = inst.req & (streak_q >= STREAK_W'(STARVE_LIMIT));

  // a pending (locked) grant is never re-arbitrated until accepted or withdrawn
  always_comb begin
    if (lock_q) begin
      grant_id = lock_id_q;
    end else if (!data.req || starved) begin
      grant_id = REQ_INST;
    end else begin
      grant_id = REQ_DATA;
    end
    grant_pkt = (grant_id == REQ_DATA) ? data_pkt : inst_pkt;
  end

  assign bus.req   = grant_pkt.req & (~fifo_full | bus.data_ok);
  assign bus.wr    = grant_pkt.wr;
  assign bus.size  = grant_pkt.size;
  assign bus.wstrb = grant_pkt.wstrb;
  assign bus.addr  = grant_pkt.addr;
  assign bus.wdata = grant_pkt.wdata;

  assign push          = bus.req & bus.addr_ok;
  assign inst.addr_ok  = push & (grant_id == REQ_INST);
  assign data.addr_ok  = push & (grant_id == REQ_DATA);

  assign pop           = bus.data_ok & ~fifo_empty;
  assign inst.data_ok  = pop & (fifo_head == REQ_INST);
  assign data.data_ok  = pop & (fifo_head == REQ_DATA);
  assign inst.rdata    = bus.rdata;
  assign data.rdata    = bus.rdata;

  assign outstanding   = fifo_count;
  assign err_stray_ok  = err_q;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (bus.req && !bus.addr_ok) begin
      lock_d    = 1'b1;
      lock_id_d = grant_id;
    end else if (push || (lock_q && !grant_pkt.req)) begin
      lock_d    = 1'b0;
    end

    streak_d = streak_q;
    if (!inst.req || inst.addr_ok) begin
      streak_d = '0;
    end else if (data.addr_ok && (streak_q < STREAK_W'(STARVE_LIMIT))) begin
      streak_d = streak_q + 1'b1;
    end

    err_d = err_q | (bus.data_ok & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= REQ_INST;
      streak_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      streak_q  <= streak_d;
      err_q     <= err_d;
    end
  end

  req_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (grant_id == REQ_DATA),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_req_arbiter : scoreboard bench with a queue-based reference model
// Revision: 1.0
// ============================================================================
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  localparam int MAXO = 4;
  localparam int LIM  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_req_arbiter_if inst_if ();
  sram_req_arbiter_if data_if ();
  sram_req_arbiter_if bus_if ();
  logic [2:0] outstanding;
  logic       err_stray_ok;

  sram_req_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .STARVE_LIMIT    (LIM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst         (inst_if),
    .data         (data_if),
    .bus          (bus_if),
    .outstanding  (outstanding),
    .err_stray_ok (err_stray_ok)
  );

  typedef struct {
    bit          id;
    logic [31:0] rdata;
  } resp_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    m_q[$];       // issue order of accepted requests, 0=inst 1=data
  bit    m_lock;
  bit    m_lock_id;
  int    m_streak;
  bit    m_err;
  resp_t exp_q[$];
  resp_t mon_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_fields();
    inst_if.wr    = 1'($urandom);
    inst_if.size  = 2'($urandom_range(0, 2));
    inst_if.wstrb = 4'($urandom);
    inst_if.addr  = $urandom;
    inst_if.wdata = $urandom;
    data_if.wr    = 1'($urandom);
    data_if.size  = 2'($urandom_range(0, 2));
    data_if.wstrb = 4'($urandom);
    data_if.addr  = $urandom;
    data_if.wdata = $urandom;
  endtask

  // Reference: one bus, FIFO of issue ids, a sticky pending grant and a starvation count.
  task automatic model_step(input bit ir, input bit dr, input bit aok, input bit dok);
    bit g, greq, breq, acc;
    if (m_lock) g = m_lock_id;
    else        g = dr && !(ir && m_streak >= LIM);
    greq = g ? dr : ir;
    breq = greq && (m_q.size() < MAXO || dok);
    acc  = breq && aok;

    chk("bus_req", bus_if.req, breq);
    if (breq) begin
      chk("bus_addr",  bus_if.addr,  g ? data_if.addr  : inst_if.addr);
      chk("bus_wdata", bus_if.wdata, g ? data_if.wdata : inst_if.wdata);
      chk("bus_ctl", {bus_if.wr, bus_if.size, bus_if.wstrb},
          g ? {data_if.wr, data_if.size, data_if.wstrb} : {inst_if.wr, inst_if.size, inst_if.wstrb});
    end
    chk("inst_addr_ok", inst_if.addr_ok, acc && !g);
    chk("data_addr_ok", data_if.addr_ok, acc && g);
    chk("outstanding", outstanding, m_q.size());
    chk("err_stray_ok", err_stray_ok, m_err);

    if (dok) begin
      if (m_q.size() == 0) m_err = 1'b1;
      else void'(m_q.pop_front());
    end
    if (acc) m_q.push_back(g);

    if (breq && !aok) begin
      m_lock = 1'b1;
      m_lock_id = g;
    end else if (acc || (m_lock && !greq)) begin
      m_lock = 1'b0;
    end

    if (!ir || (acc && !g)) m_streak = 0;
    else if (acc && g && m_streak < LIM) m_streak++;
  endtask

  task automatic cycle(input bit ir, input bit dr, input bit aok, input bit dok, input logic [31:0] rd);
    resp_t r;
    @(posedge clk); #1;
    rand_fields();
    inst_if.req    = ir;
    data_if.req    = dr;
    bus_if.addr_ok = aok;
    bus_if.data_ok = dok;
    bus_if.rdata   = rd;
    if (dok && m_q.size() > 0) begin
      r.id    = m_q[0];
      r.rdata = rd;
      exp_q.push_back(r);
    end
    @(negedge clk);
    model_step(ir, dr, aok, dok);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset          = 1'b1;
    inst_if.req    = 1'b0;
    data_if.req    = 1'b0;
    bus_if.addr_ok = 1'b0;
    bus_if.data_ok = 1'b0;
    bus_if.rdata   = '0;
    rand_fields();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_q.delete();
    m_lock   = 1'b0;
    m_streak = 0;
    m_err    = 1'b0;
  endtask

  task automatic drain();
    while (m_q.size() > 0) cycle(0, 0, 0, 1, $urandom);
  endtask

  // Monitor: each response the DUT presents must match the next expected one.
  always @(negedge clk) begin
    if (inst_if.data_ok || data_if.data_ok) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_data_ok", {inst_if.data_ok, data_if.data_ok}, 2'b00);
      end else begin
        mon_r = exp_q.pop_front();
        chk("resp_port", {inst_if.data_ok, data_if.data_ok}, mon_r.id ? 2'b01 : 2'b10);
        chk("resp_rdata", mon_r.id ? data_if.rdata : inst_if.rdata, mon_r.rdata);
      end
    end else if (exp_q.size() > 0) begin
      mon_r = exp_q.pop_front();
      chk("missing_data_ok", {inst_if.data_ok, data_if.data_ok}, mon_r.id ? 2'b01 : 2'b10);
    end
  end

  initial begin
    bit ir, dr, aok, dok;
    reset = 1'b1;
    do_reset();
    cycle(0, 0, 0, 0, 0);

    // single inst read with a 3-cycle response latency
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'hDEADBEEF);

    // contention with a stalled bus and a withdrawn data request
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0);
    drain();

    // starvation guard
    for (int i = 0; i < 6; i++) cycle(1, 1, 1, m_q.size() > 0, $urandom);
    drain();

    // fill the FIFO, then push and pop together at full
    repeat (4) cycle(1, 0, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 1, 32'h0000_00A5);
    drain();

    // interleaved return order
    cycle(1, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 0, 0, 1, i);

    // stray response is sticky until reset
    cycle(0, 0, 0, 1, 32'h55);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ir  = $urandom_range(0, 3) != 0;
      dr  = $urandom_range(0, 3) != 0;
      aok = $urandom_range(0, 2) != 0;
      dok = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      cycle(ir, dr, aok, dok, $urandom);
    end
    drain();
    cycle(0, 0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like bus between two requesters: the instruction-fetch port and the pre_MEM data port.
- Signals per request: req/wr/size/wstrb/addr/wdata, handshakes addr_ok/data_ok.
- Sits between the CPU core and the AXI bridge. It arbitrates address handshakes, holds a grant stable until it is accepted, and tracks outstanding requests in an order FIFO so that each in-order data_ok/rdata returns to the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 4, depth of the return-order FIFO; power of two, at least 2.
- STARVE_LIMIT, 4, number of consecutive accepted data-port requests while inst_req is pending; after this many, the instruction port gets priority.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  instruction request
- inst_wr  in  1  write (always 0 in practice; still forwarded)
- inst_size  in  2  byte count code 0/1/2
- inst_wstrb  in  4  byte enables
- inst_addr  in  32  physical address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  instruction request accepted
- inst_data_ok  out  1  instruction response valid
- inst_rdata  out  32  instruction read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data-port request, same meaning as inst_*
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata  out  1/1/2/4/32/32  shared bus request
- bus_addr_ok  in  1  bus accepted the request
- bus_data_ok  in  1  bus response valid, in issue order
- bus_rdata  in  32  bus read data
- outstanding  out  log2(MAX_OUTSTANDING)+1  current FIFO occupancy
- err_stray_ok  out  1  sticky: bus_data_ok arrived with an empty FIFO

Behaviour:
- Reset values: bus_req=0, all *_addr_ok=0, all *_data_ok=0, outstanding=0, err_stray_ok=0, lock=0, streak=0.
- The request path is combinational, zero latency. bus_* mirrors the granted requester's fields. The winner's addr_ok = bus_addr_ok & bus_req. The loser's addr_ok = 0.
- Grant selection, evaluated only when lock=0:
  - Data port wins by default.
  - Instruction port wins if data_req=0, or if streak reaches STARVE_LIMIT while inst_req=1.
- Lock register:
  - Set when bus_req=1 and bus_addr_ok=0; it stores the granted id.
  - While set, the stored grant is forced and both inputs are ignored for selection.
  - Cleared on bus_addr_ok.
  - If the locked requester drops req (pre_MEM flush), lock clears the next cycle and bus_req falls. The bus tolerates a withdrawn req.
- Streak counter:
  - Increments on each accepted data handshake while inst_req=1.
  - Clears on an accepted instruction handshake or when inst_req=0.
  - Saturates at STARVE_LIMIT.
- FIFO full: when outstanding==MAX_OUTSTANDING, bus_req=0 and both addr_ok=0. Lock is held, not cleared.
- Push: on bus_req & bus_addr_ok, push the 1-bit id (0=inst, 1=data).
- Pop: on bus_data_ok, pop the head. head=0 raises inst_data_ok, head=1 raises data_data_ok. bus_rdata fans out to both rdata ports unmodified.
- Push and pop in the same cycle: occupancy unchanged. This is allowed at full, since the pop frees the slot in the same cycle, so bus_req may stay asserted at full when bus_data_ok=1.
- Pointers wrap modulo MAX_OUTSTANDING. Occupancy uses one extra bit to distinguish full from empty.
- Stray response: bus_data_ok with an empty FIFO raises neither data_ok, sets err_stray_ok, and leaves pointers unchanged.
- Reset mid-operation: FIFO, lock and streak are cleared. Responses to pre-reset requests then count as stray, so upstream must reset the bus together with this block.

Decomposition:
- cpu_defs.svh gains:
  - req_id_t enum {REQ_INST=0, REQ_DATA=1}
  - sram_req_t packed struct {req, wr, size, wstrb, addr, wdata}
  - constants for MAX_OUTSTANDING and STARVE_LIMIT
- Sub-module req_order_fifo: 1-bit-wide synchronous FIFO with push, pop, full, empty and count, parameterised by depth. Arbitration and the lock stay in the top module.

Test Plan:
- Single inst read at 0x1FC00000, bus_addr_ok at once, bus_data_ok 3 cycles later with rdata 0xDEADBEEF -> inst_addr_ok 1 cycle, inst_data_ok 1 cycle with 0xDEADBEEF, data_data_ok stays 0.
- inst_req and data_req both high from idle -> data granted first. With bus_addr_ok held low for 5 cycles while data_req is withdrawn for 2 of them -> grant does not switch to inst until lock clears.
- data_req held high for 6 accepted handshakes with inst_req high -> 4 data grants, then inst granted, then streak resets to 0.
- Issue 4 reads without any data_ok -> outstanding=4, bus_req=0. A cycle with bus_data_ok=1 and both reqs pending -> one new push accepted, outstanding stays 4.
- Interleaved order inst, data, inst, data pushed; bus_data_ok pulses with rdata 1, 2, 3, 4 -> inst gets 1 and 3, data gets 2 and 4, in order.
- bus_data_ok with outstanding=0 -> no *_data_ok, err_stray_ok=1 and stays 1 until reset; after reset, err_stray_ok=0 and outstanding=0.
